// File: rtl/pkg_alu.sv
// pkg_alu: ALU operation codes and chunk geometry shared by ALU clients.
package pkg_alu;
  localparam int CHUNK_WIDTH = 16;
  localparam int FLAG_WIDTH  = 4;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_MULW = 4'd8
  } alu_op_t;
endpackage

// File: rtl/pkg_mul_seq.sv
// pkg_mul_seq: state encoding for the sequential chunked multiplier.
package pkg_mul_seq;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    SHL  = 3'd2,
    ADD  = 3'd3,
    DONE = 3'd4
  } state_t;
endpackage

// File: rtl/pkg_reg.sv
// pkg_reg: register-file wide constants shared across the datapath.
package pkg_reg;
  localparam int REG_WIDTH = 64;
endpackage

// File: rtl/if_alu.sv
// if_alu: request/response bundle between an ALU client and the ALU device.
interface if_alu #(
  parameter int WIDTH = pkg_reg::REG_WIDTH
);
  import pkg_alu::*;

  alu_op_t                op;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [WIDTH-1:0]       s;
  logic [FLAG_WIDTH-1:0]  flags;

  modport client (output op, a, b, input s, flags);
  modport device (input op, a, b, output s, flags);
endinterface

// File: rtl/mul_seq_idx.sv
// mul_seq_idx: walks the chunk pairs (i outer, j inner) with i+j < N and
// reports the shift amount 16*(i+j) and whether the current pair is the last.
module mul_seq_idx
  import pkg_alu::*;
#(
  parameter int N  = 4,
  parameter int IW = 2,
  parameter int SW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [SW-1:0] shift,
  output logic          last
);
  logic [IW-1:0] i_reg;
  logic [IW-1:0] j_reg;
  logic          row_end;

  // Pairs above the anti-diagonal only affect bits beyond the product width.
  assign row_end = (i_reg + j_reg) == IW'(N - 1);
  assign last    = row_end && (i_reg == IW'(N - 1));
  assign shift   = SW'(32'(i_reg + j_reg) * CHUNK_WIDTH);
  assign i       = i_reg;
  assign j       = j_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_reg <= '0;
      j_reg <= '0;
    end else if (clr) begin
      i_reg <= '0;
      j_reg <= '0;
    end else if (adv) begin
      if (row_end) begin
        i_reg <= i_reg + IW'(1);
        j_reg <= '0;
      end else begin
        j_reg <= j_reg + IW'(1);
      end
    end
  end
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH x WIDTH -> WIDTH multiplier built from 16-bit chunk products
// run through a shared ALU (MULW, SHL, ADD per pair). Optional: ALU_MUL_SEQ_SKIP_ZERO_EN.
module alu_mul_seq
  import pkg_alu::*, pkg_mul_seq::*;
#(
  parameter int WIDTH = pkg_reg::REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  if_alu.client            alu
);
  localparam int N  = WIDTH / CHUNK_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(WIDTH);

  state_t                 state_reg;
  logic [WIDTH-1:0]       x_reg;
  logic [WIDTH-1:0]       y_reg;
  logic [WIDTH-1:0]       t_reg;
  logic [WIDTH-1:0]       sum_reg;
  logic [IW-1:0]          idx_i;
  logic [IW-1:0]          idx_j;
  logic [SW-1:0]          idx_shift;
  logic                   idx_last;
  logic                   idx_clr;
  logic                   idx_adv;
  logic [CHUNK_WIDTH-1:0] x_chunk;
  logic [CHUNK_WIDTH-1:0] y_chunk;
  logic                   pair_skip;

  assign x_chunk = x_reg[CHUNK_WIDTH*idx_i +: CHUNK_WIDTH];
  assign y_chunk = y_reg[CHUNK_WIDTH*idx_j +: CHUNK_WIDTH];

`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
  assign pair_skip = (x_chunk == '0) || (y_chunk == '0);
`else
  assign pair_skip = 1'b0;
`endif

  assign idx_clr = (state_reg == IDLE) && start;
  assign idx_adv = (state_reg == ADD) || ((state_reg == MUL) && pair_skip);

  mul_seq_idx #(
    .N  (N),
    .IW (IW),
    .SW (SW)
  ) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clr   (idx_clr),
    .adv   (idx_adv),
    .i     (idx_i),
    .j     (idx_j),
    .shift (idx_shift),
    .last  (idx_last)
  );

  // ALU request decoded from the state; the result is consumed in the same cycle.
  always_comb begin
    alu.op = ALU_NOP;
    alu.a  = '0;
    alu.b  = '0;
    case (state_reg)
      MUL: begin
        if (!pair_skip) begin
          alu.op = ALU_MULW;
          alu.a  = WIDTH'(x_chunk);
          alu.b  = WIDTH'(y_chunk);
        end
      end
      SHL: begin
        alu.op = ALU_SHL;
        alu.a  = WIDTH'(idx_shift);
        alu.b  = t_reg;
      end
      ADD: begin
        alu.op = ALU_ADD;
        alu.a  = t_reg;
        alu.b  = sum_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      prod      <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      t_reg     <= '0;
      sum_reg   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg     <= x;
            y_reg     <= y;
            t_reg     <= '0;
            sum_reg   <= '0;
            ready     <= 1'b0;
            state_reg <= MUL;
          end
        end
        MUL: begin
          if (pair_skip) begin
            if (idx_last) begin
              prod      <= sum_reg;
              done      <= 1'b1;
              state_reg <= DONE;
            end
          end else begin
            t_reg     <= alu.s;
            state_reg <= SHL;
          end
        end
        SHL: begin
          t_reg     <= alu.s;
          state_reg <= ADD;
        end
        ADD: begin
          sum_reg <= alu.s;
          if (idx_last) begin
            prod      <= alu.s;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            state_reg <= MUL;
          end
        end
        DONE: begin
          ready     <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
